// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-wide slice per stage, carries
// registered between stages, with valid/ready flow control and a squash input.
module pipelined_add_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             Carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; the whole pipe advances together whenever the output slot is free or drained.
  logic adv;

  logic [STAGES-1:0] v_q, c_q, sel_q, am_q, bm_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  y_q [STAGES];

  logic [STAGES-1:0] v_d, c_d, sel_d, am_d, bm_d;
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  y_d [STAGES];
  logic [WIDTH-1:0]  y_n [STAGES];
  logic [CHUNK:0]    sum [STAGES];

  logic [WIDTH-1:0]  y_last;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[LAST];
  assign y_last    = y_q[LAST];

  // Stage k sees either the fresh operands (k = 0) or the registers of stage k-1.
  always_comb begin
    a_d[0]   = A;
    b_d[0]   = B ^ {WIDTH{Sel}};
    y_d[0]   = '0;
    v_d[0]   = in_valid;
    c_d[0]   = Sel;
    sel_d[0] = Sel;
    am_d[0]  = A[WIDTH-1];
    bm_d[0]  = B[WIDTH-1];
    for (int k = 1; k < STAGES; k++) begin
      a_d[k]   = a_q[k-1];
      b_d[k]   = b_q[k-1];
      y_d[k]   = y_q[k-1];
      v_d[k]   = v_q[k-1];
      c_d[k]   = c_q[k-1];
      sel_d[k] = sel_q[k-1];
      am_d[k]  = am_q[k-1];
      bm_d[k]  = bm_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      sum[k] = {1'b0, a_d[k][k*CHUNK +: CHUNK]} + {1'b0, b_d[k][k*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, c_d[k]};
      y_n[k] = y_d[k];
      y_n[k][k*CHUNK +: CHUNK] = sum[k][CHUNK-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      v_q <= '0;
    end else if (adv) begin
      v_q <= v_d;
    end
    if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        y_q[k] <= y_n[k];
        c_q[k] <= sum[k][CHUNK];
      end
      sel_q <= sel_d;
      am_q  <= am_d;
      bm_q  <= bm_d;
    end
  end

  // Flags derive from the output registers and are forced low while idle.
  always_comb begin
    Y         = '0;
    Carry_out = 1'b0;
    overflow  = 1'b0;
    zero      = 1'b0;
    negative  = 1'b0;
    if (out_valid) begin
      Y         = y_last;
      Carry_out = c_q[LAST];
      negative  = y_last[WIDTH-1];
      zero      = (y_last == '0);
      overflow  = sel_q[LAST]
                ? ((am_q[LAST] != bm_q[LAST]) && (y_last[WIDTH-1] != am_q[LAST]))
                : ((am_q[LAST] == bm_q[LAST]) && (y_last[WIDTH-1] != am_q[LAST]));
    end
  end

endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
- Parametrised, pipelined successor to the single-cycle 32-bit ripple add/sub in the ALU datapath.
- Splits a WIDTH-bit add/subtract into STAGES equal chunks, one chunk per clock, carrying between stages through registers.
- Adds valid/ready flow control, a flush input for pipeline squash, and zero/negative flags alongside carry and overflow.
- Used where a full-width ripple carry fails timing, such as wide datapaths and address generation.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth; each stage adds CHUNK = WIDTH/STAGES bits; legal range 1..WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  squash all in-flight operations.
- in_valid  input  1  A/B/Sel valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Sel  input  1  0: ADD, 1: SUB (A - B).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- Y  output  WIDTH  result, modulo 2^WIDTH.
- Carry_out  output  1  carry out of MSB. ADD: unsigned carry. SUB: 1 = no borrow (A >= B unsigned).
- overflow  output  1  signed overflow.
- zero  output  1  Y == 0.
- negative  output  1  Y[WIDTH-1].

Behaviour:
- Reset: rst sampled at the rising edge clears every stage valid bit. Effects while asserted and after:
  - out_valid = 0 and in_ready = 1.
  - Y, Carry_out, overflow, zero and negative are driven to 0 while out_valid = 0.
  - Data registers need no reset.
- Reset mid-operation: all in-flight operations are discarded; none emerges afterwards.
- Advance enable: adv = !out_valid || out_ready; in_ready = adv (combinational).
  - When adv = 0, every stage holds all of its registers.
  - Inputs are captured only when in_valid && in_ready.
- Arithmetic:
  - B_eff = B XOR {WIDTH{Sel}}; carry-in to chunk 0 = Sel.
  - Stage k (0..STAGES-1) adds chunk k of A and B_eff plus the registered carry from stage k-1.
  - Operand chunks not yet consumed travel skewed with the operation; result chunks already produced travel with it.
  - Sel travels with the operation, as do A[MSB] and B[MSB] for the overflow computation.
- Latency: exactly STAGES cycles from accept to out_valid, with no stall.
  - STAGES = 1: result registered, out_valid the cycle after accept.
- Throughput: one operation per cycle when out_ready is held high. Back-to-back operations never mix carries.
- Flags are computed from the final stage; registered or combinational from the output register, designer's choice, but they must be valid whenever out_valid = 1.
  - overflow = (!Sel && A[MSB]==B[MSB] && Y[MSB]!=A[MSB]) || (Sel && A[MSB]!=B[MSB] && Y[MSB]!=A[MSB]).
  - zero = (Y == 0); negative = Y[MSB].
- Handshake rules:
  - Y and the flags must remain stable while out_valid && !out_ready.
  - Once asserted, out_valid may fall only after a handshake, flush or rst.
- Flush: flush sampled high clears all stage valid bits next cycle, including the output stage.
  - Any input presented in the same cycle is dropped, even if in_ready = 1.
  - rst and flush asserted together behave as rst.
- Simultaneous events: an output handshake and an input accept in the same cycle are both honoured; the pipeline shifts by one.
- Empty bubbles (stage valid = 0) advance when adv = 1 and never raise out_valid.

Test Plan:
- Default params, ADD A=0x7FFFFFFF, B=0x00000001, out_ready=1 → after 4 cycles Y=0x80000000, overflow=1, Carry_out=0, negative=1, zero=0.
- SUB A=0x00000000, B=0x00000001 → Y=0xFFFFFFFF, Carry_out=0, overflow=0. SUB A=5, B=5 → Y=0, zero=1, Carry_out=1. SUB A=0x80000000, B=1 → Y=0x7FFFFFFF, overflow=1, Carry_out=1.
- Carry-propagation chain: ADD 0xFFFFFFFF + 1 → Y=0, Carry_out=1, zero=1. Issue it back-to-back with 1+1 → next cycle Y=2, Carry_out=0, with no carry leak between the two operations.
- Backpressure: stream 6 operations, hold out_ready=0 for 3 cycles once out_valid rises. Required:
  - in_ready=0 while stalled and the output is held stable.
  - All 6 results emerge in order, none lost or duplicated.
- Flush with 3 operations in flight: assert flush for 1 cycle → out_valid stays 0 and none of the 3 ever emerges. An operation issued the cycle after flush emerges 4 cycles later, correct.
- Reset mid-operation, then parametrisation sweep. After reset, no stale results appear. Then repeat the random compare against a golden A±B model:
  - WIDTH=32 with STAGES=1, 2 and 8.
  - WIDTH=64 with STAGES=4.
  - Check latency == STAGES in every configuration.
